// File: rtl/ps_frame_gen.sv
// Power-supply link frame generator: SOP, ADDR, CMD, N_DATA payload, EOP, with IDLE fill between frames.
// Trigger requests are merged into one pending flag; data requests wait in a single holding register.
module ps_frame_gen #(
  parameter int          N_DATA    = 6,
  parameter logic [7:0]  SOP       = 8'h3C,
  parameter logic [7:0]  EOP       = 8'hBC,
  parameter logic [7:0]  IDLE      = 8'h5C,
  parameter logic [7:0]  CMD_TRIG  = 8'h70,
  parameter logic [7:0]  CMD_DATA  = 8'h40,
  parameter logic [7:0]  TRIG_ADDR = 8'h00,
  parameter int          GAP       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trig_req,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [7:0]            wr_addr,
  input  logic [8*N_DATA-1:0]   wr_data,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_k,
  output logic                  tx_sof,
  output logic                  tx_eof,
  output logic                  busy,
  output logic [7:0]            trig_ovf_cnt
);

  localparam int IDX_W = (N_DATA > 1) ? $clog2(N_DATA) : 1;
  localparam int GAP_W = $clog2(GAP + 1) + 1;
  localparam logic [GAP_W:0] GAP_V = (GAP_W + 1)'(GAP);

  typedef enum logic [2:0] {S_IDLE, S_SOP, S_ADDR, S_CMD, S_DATA, S_EOP} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;
  logic                is_trig_reg;
  logic                trig_pending_reg;
  logic [7:0]          trig_ovf_cnt_reg;
  logic                hold_full_reg;
  logic [7:0]          hold_addr_reg;
  logic [8*N_DATA-1:0] hold_data_reg;
  logic [7:0]          tx_data_reg;
  logic                tx_k_reg;
  logic                tx_sof_reg;
  logic                tx_eof_reg;

  logic [7:0]       payload [N_DATA];
  logic [IDX_W-1:0] idx_inc;
  logic             gap_met;
  logic             start_frame;
  logic             start_trig;
  logic             last_byte;
  logic             eop_data;

  for (genvar gi = 0; gi < N_DATA; gi++) begin : g_payload
    assign payload[gi] = hold_data_reg[8*(N_DATA-1-gi) +: 8];
  end

  // gap_cnt counts IDLE bytes already on the line before the current one.
  assign gap_met     = ({1'b0, gap_cnt_reg} + (GAP_W + 1)'(1)) >= GAP_V;
  assign idx_inc     = idx_reg + IDX_W'(1);
  assign last_byte   = (idx_reg == IDX_W'(N_DATA - 1));
  assign start_frame = tx_ready && (state_reg == S_IDLE) && gap_met && (trig_pending_reg || hold_full_reg);
  assign start_trig  = start_frame && trig_pending_reg;
  assign eop_data    = tx_ready && (state_reg == S_DATA) && last_byte && !is_trig_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_pending_reg <= 1'b0;
      trig_ovf_cnt_reg <= 8'd0;
      hold_full_reg    <= 1'b0;
      hold_addr_reg    <= 8'd0;
      hold_data_reg    <= '0;
    end else begin
      if (trig_req && trig_pending_reg && (trig_ovf_cnt_reg != 8'hFF))
        trig_ovf_cnt_reg <= trig_ovf_cnt_reg + 8'd1;
      if (trig_req)
        trig_pending_reg <= 1'b1;
      else if (start_trig)
        trig_pending_reg <= 1'b0;
      if (wr_valid && !hold_full_reg) begin
        hold_full_reg <= 1'b1;
        hold_addr_reg <= wr_addr;
        hold_data_reg <= wr_data;
      end else if (eop_data) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      gap_cnt_reg <= GAP_W'(GAP);
      is_trig_reg <= 1'b0;
      tx_data_reg <= IDLE;
      tx_k_reg    <= 1'b1;
      tx_sof_reg  <= 1'b0;
      tx_eof_reg  <= 1'b0;
    end else if (tx_ready) begin
      tx_sof_reg <= 1'b0;
      tx_eof_reg <= 1'b0;
      tx_k_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          tx_k_reg <= 1'b1;
          if (start_frame) begin
            state_reg   <= S_SOP;
            is_trig_reg <= trig_pending_reg;
            tx_data_reg <= SOP;
            tx_sof_reg  <= 1'b1;
          end else begin
            tx_data_reg <= IDLE;
            if ({1'b0, gap_cnt_reg} < GAP_V)
              gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        S_SOP: begin
          state_reg   <= S_ADDR;
          tx_data_reg <= is_trig_reg ? TRIG_ADDR : hold_addr_reg;
        end
        S_ADDR: begin
          state_reg   <= S_CMD;
          tx_data_reg <= is_trig_reg ? CMD_TRIG : CMD_DATA;
        end
        S_CMD: begin
          state_reg   <= S_DATA;
          idx_reg     <= '0;
          tx_data_reg <= is_trig_reg ? 8'h00 : payload[0];
        end
        S_DATA: begin
          if (last_byte) begin
            state_reg   <= S_EOP;
            tx_data_reg <= EOP;
            tx_k_reg    <= 1'b1;
            tx_eof_reg  <= 1'b1;
          end else begin
            idx_reg     <= idx_inc;
            tx_data_reg <= is_trig_reg ? 8'h00 : payload[idx_inc];
          end
        end
        default: begin
          state_reg   <= S_IDLE;
          gap_cnt_reg <= '0;
          tx_data_reg <= IDLE;
          tx_k_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_data      = tx_data_reg;
  assign tx_k         = tx_k_reg;
  assign tx_sof       = tx_sof_reg;
  assign tx_eof       = tx_eof_reg;
  assign wr_ready     = ~hold_full_reg;
  assign busy         = (state_reg != S_IDLE) || trig_pending_reg || hold_full_reg;
  assign trig_ovf_cnt = trig_ovf_cnt_reg;

endmodule

// File: tb/tb_ps_frame_gen.sv
// Bench for ps_frame_gen: directed scenarios plus random traffic, checked every cycle against
// a frame-level model (pending flag, one-entry hold, current frame as a byte array).
module tb_ps_frame_gen;

  localparam int N_DATA = 6;
  localparam int LEN    = N_DATA + 4;
  localparam int GAP    = 1;
  localparam logic [7:0] SOP = 8'h3C, EOP = 8'hBC, IDLE = 8'h5C;
  localparam logic [7:0] CMD_TRIG = 8'h70, CMD_DATA = 8'h40, TRIG_ADDR = 8'h00;

  typedef logic [7:0] frame_t [LEN];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig_req = 1'b0;
  logic wr_valid = 1'b0;
  logic tx_ready = 1'b1;
  logic [7:0] wr_addr = 8'd0;
  logic [8*N_DATA-1:0] wr_data = '0;
  logic wr_ready, tx_k, tx_sof, tx_eof, busy;
  logic [7:0] tx_data, trig_ovf_cnt;

  always #5 clk = ~clk;

  ps_frame_gen #(.N_DATA(N_DATA), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .trig_req(trig_req), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .tx_ready(tx_ready), .tx_data(tx_data), .tx_k(tx_k),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy), .trig_ovf_cnt(trig_ovf_cnt)
  );

  int checks = 0;
  int errors = 0;

  int                  m_pos;
  bit                  m_trig;
  int                  m_idles;
  bit                  m_pend;
  bit                  m_full;
  logic [7:0]          m_addr;
  logic [8*N_DATA-1:0] m_data;
  int                  m_ovf;
  frame_t              m_frame;
  logic [7:0]          line_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t make_frame(input bit trig, input logic [7:0] addr, input logic [8*N_DATA-1:0] data);
    frame_t f;
    f[0] = SOP;
    f[1] = trig ? TRIG_ADDR : addr;
    f[2] = trig ? CMD_TRIG : CMD_DATA;
    for (int i = 0; i < N_DATA; i++)
      f[3+i] = trig ? 8'h00 : 8'(data >> (8*(N_DATA-1-i)));
    f[LEN-1] = EOP;
    return f;
  endfunction

  task automatic model_reset();
    m_pos = -1; m_trig = 0; m_idles = GAP; m_pend = 0; m_full = 0;
    m_addr = 8'd0; m_data = '0; m_ovf = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit start_trig = 0;
    bit eop_data = 0;
    if (tx_ready) begin
      if (m_pos < 0) begin
        if (m_idles >= GAP && (m_pend || m_full)) begin
          m_trig = m_pend;
          start_trig = m_pend;
          m_frame = make_frame(m_pend, m_addr, m_data);
          m_pos = 0;
        end else if (m_idles < GAP) begin
          m_idles++;
        end
      end else if (m_pos == LEN-1) begin
        m_pos = -1;
        m_idles = 1;
      end else begin
        m_pos++;
        if (m_pos == LEN-1 && !m_trig) eop_data = 1;
      end
    end
    if (trig_req && m_pend && m_ovf < 255) m_ovf++;
    if (trig_req) m_pend = 1;
    else if (start_trig) m_pend = 0;
    if (wr_valid && !m_full) begin
      m_full = 1; m_addr = wr_addr; m_data = wr_data;
    end else if (eop_data) begin
      m_full = 0;
    end
  endtask

  task automatic cycle();
    bit en;
    @(posedge clk);
    en = tx_ready;
    model_edge();
    #1;
    if (en) line_q.push_back(tx_data);
    check("tx_data", tx_data, (m_pos < 0) ? IDLE : m_frame[m_pos]);
    check("tx_k", tx_k, (m_pos < 0 || m_pos == 0 || m_pos == LEN-1));
    check("tx_sof", tx_sof, m_pos == 0);
    check("tx_eof", tx_eof, m_pos == LEN-1);
    check("wr_ready", wr_ready, !m_full);
    check("busy", busy, (m_pos >= 0) || m_pend || m_full);
    check("trig_ovf_cnt", trig_ovf_cnt, m_ovf);
    if (en && m_pos == LEN-1)
      $display("frame %s addr=%02h ovf=%0d", m_trig ? "trig" : "data", m_frame[1], m_ovf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    check("rst_tx_data", tx_data, IDLE);
    check("rst_tx_k", tx_k, 1);
    check("rst_sof_eof", {tx_sof, tx_eof}, 2'b00);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", trig_ovf_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain(input int max, input bit rnd);
    bit done = 0;
    for (int i = 0; i < max; i++) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      cycle();
      if (m_pos < 0 && !m_pend && !m_full) begin
        done = 1;
        break;
      end
    end
    tx_ready = 1;
    check("drain_timeout", done, 1);
  endtask

  task automatic expect_frame(input string tag, input frame_t exp, input bit lead_any);
    logic [7:0] got;
    if (lead_any) begin
      while (line_q.size() > 0 && line_q[0] == IDLE) void'(line_q.pop_front());
    end else begin
      for (int i = 0; i < GAP; i++) begin
        got = (line_q.size() > 0) ? line_q.pop_front() : 8'hxx;
        check({tag, "_gap"}, got, IDLE);
      end
    end
    for (int i = 0; i < LEN; i++) begin
      got = (line_q.size() > 0) ? line_q.pop_front() : 8'hxx;
      check(tag, got, exp[i]);
    end
  endtask

  task automatic write_req(input logic [7:0] a, input logic [8*N_DATA-1:0] d);
    wr_valid = 1; wr_addr = a; wr_data = d;
    cycle();
    wr_valid = 0;
  endtask

  initial begin
    frame_t trig_f, d3_f, a_f, b_f;
    int nsop;
    bit acc;
    trig_f = make_frame(1, 8'h00, '0);
    d3_f   = make_frame(0, 8'h12, 48'h0102030405A6);
    a_f    = make_frame(0, 8'hA1, 48'hDEADBEEF0011);
    b_f    = make_frame(0, 8'hB2, 48'h998877665544);

    // Idle after reset.
    model_reset();
    do_reset();
    repeat (5) cycle();
    check("idle_byte", tx_data, 8'h5C);

    // Trigger frame and one-cycle request latency.
    line_q.delete();
    trig_req = 1; cycle(); trig_req = 0;
    cycle();
    check("latency_sof", {tx_sof, tx_data}, {1'b1, 8'h3C});
    drain(50, 0);
    expect_frame("trig_frame", trig_f, 1);

    // Data frame.
    line_q.delete();
    write_req(8'h12, 48'h0102030405A6);
    check("wr_ready_low", wr_ready, 0);
    drain(50, 0);
    expect_frame("data_frame", d3_f, 1);

    // Data frame, then a merged trigger, then a second write: trigger goes first.
    line_q.delete();
    write_req(8'hA1, 48'hDEADBEEF0011);
    repeat (3) cycle();
    trig_req = 1; cycle(); trig_req = 0;
    wr_valid = 1; wr_addr = 8'hB2; wr_data = 48'h998877665544;
    for (int i = 0; i < 40; i++) begin
      acc = wr_ready;
      cycle();
      if (acc) break;
    end
    wr_valid = 0;
    check("second_write_accepted", acc, 1);
    drain(100, 0);
    expect_frame("b2b_data_a", a_f, 1);
    expect_frame("b2b_trig", trig_f, 0);
    expect_frame("b2b_data_b", b_f, 0);

    // Three triggers during one frame merge into one trigger frame.
    do_reset();
    line_q.delete();
    write_req(8'h21, 48'h112233445566);
    for (int p = 0; p < 3; p++) begin
      trig_req = 1; cycle(); trig_req = 0; cycle();
    end
    check("ovf_two", trig_ovf_cnt, 8'd2);
    drain(100, 0);
    nsop = 0;
    foreach (line_q[i]) if (line_q[i] == SOP) nsop++;
    check("merged_frames", nsop, 2);

    // Overflow counter saturation while the FSM is stalled.
    tx_ready = 0;
    trig_req = 1;
    repeat (301) cycle();
    trig_req = 0;
    check("ovf_saturate", trig_ovf_cnt, 8'd255);
    tx_ready = 1;
    drain(50, 0);

    // Randomly stalled serializer sees the same byte sequence.
    line_q.delete();
    write_req(8'h12, 48'h0102030405A6);
    drain(300, 1);
    expect_frame("stall_frame", d3_f, 1);

    // Reset while payload byte 2 is on the line.
    write_req(8'h12, 48'h0102030405A6);
    for (int i = 0; i < 30 && !(m_pos == 5); i++) cycle();
    check("at_payload2", tx_data, 8'h03);
    rst_n = 0;
    model_reset();
    #1;
    check("midrst_tx_data", tx_data, IDLE);
    check("midrst_wr_ready", wr_ready, 1);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      trig_req = ($urandom_range(0, 24) == 0);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_addr  = 8'($urandom);
      wr_data  = {16'($urandom), 32'($urandom)};
      tx_ready = ($urandom_range(0, 9) != 0);
      cycle();
    end
    trig_req = 0;
    wr_valid = 0;
    drain(200, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
